crcu_unit_rst_sequencer: RTL and testbench

//  Sequences software-requested unit resets in the CRCU. Serves NUM_UNITS rst_ctl_reg words (APB-programmed)

---
 rtl/crcu_rst_pkg.sv | 19 +
 rtl/crcu_rr_arbiter.sv | 34 +++
 rtl/crcu_unit_rst_sequencer.sv | 162 ++++++++++++++++
 tb/tb_crcu_unit_rst_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/crcu_rst_pkg.sv
// Shared types and rst_ctl_reg field positions for the CRCU unit reset sequencer.
package crcu_rst_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ASSERT,
    HOLD,
    RELEASE,
    SETTLE,
    DONE
  } seq_state_e;

  localparam int unsigned RST_CTL_W     = 32;
  localparam int unsigned RST_EN_BIT    = 0;
  localparam int unsigned RST_ASYNC_BIT = 1;
  localparam int unsigned RST_POL_BIT   = 2;
  localparam int unsigned RST_HOLD_LSB  = 8;

endpackage

// File: rtl/crcu_rr_arbiter.sv
// Round-robin pick over pending unit requests: the search starts at ptr and walks upward with wrap.
module crcu_rr_arbiter #(
  parameter int unsigned NUM_UNITS = 4
) (
  input  logic [NUM_UNITS-1:0]         pending,
  input  logic [$clog2(NUM_UNITS)-1:0] ptr,
  output logic                         grant_vld_c,
  output logic [NUM_UNITS-1:0]         grant_c,
  output logic [$clog2(NUM_UNITS)-1:0] grant_idx_c
);

  localparam int unsigned IDX_W = $clog2(NUM_UNITS);
  localparam int unsigned POS_W = IDX_W + 1;

  logic [POS_W-1:0] pos;

  // The first pending unit at or after ptr wins.
  always_comb begin
    grant_vld_c = 1'b0;
    grant_c     = '0;
    grant_idx_c = '0;
    pos         = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      pos = POS_W'(ptr) + POS_W'(i);
      if (pos >= POS_W'(NUM_UNITS)) pos = pos - POS_W'(NUM_UNITS);
      if (!grant_vld_c && pending[pos[IDX_W-1:0]]) begin
        grant_vld_c               = 1'b1;
        grant_c[pos[IDX_W-1:0]]   = 1'b1;
        grant_idx_c               = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/crcu_unit_rst_sequencer.sv
// Sequences software-requested unit resets through one shared assert/hold/release/settle FSM,
// serving units round-robin and applying each unit's enable, type and polarity to its reset line.
module crcu_unit_rst_sequencer #(
  parameter int unsigned NUM_UNITS  = 4,
  parameter int unsigned HOLD_W     = 8,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic                         CRCU_CLK,
  input  logic                         CRCU_RST,
  input  logic [NUM_UNITS*32-1:0]      rst_ctl_reg,
  input  logic [NUM_UNITS-1:0]         rst_req,
  output logic [NUM_UNITS-1:0]         unit_rst,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NUM_UNITS)-1:0] done_id
);

  import crcu_rst_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_UNITS);

  logic [NUM_UNITS-1:0] en;
  logic [NUM_UNITS-1:0] async_t;
  logic [NUM_UNITS-1:0] pol;
  logic [HOLD_W-1:0]    hold [NUM_UNITS];
  logic                 ctl_unused;

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_ctl
    assign en[u]      = rst_ctl_reg[u*RST_CTL_W + RST_EN_BIT];
    assign async_t[u] = rst_ctl_reg[u*RST_CTL_W + RST_ASYNC_BIT];
    assign pol[u]     = rst_ctl_reg[u*RST_CTL_W + RST_POL_BIT];
    assign hold[u]    = rst_ctl_reg[u*RST_CTL_W + RST_HOLD_LSB +: HOLD_W];
  end
  assign ctl_unused = ^rst_ctl_reg;

  seq_state_e           state_q, state_nxt;
  logic [HOLD_W-1:0]    cnt_q, cnt_nxt;
  logic [IDX_W-1:0]     gidx_q, gidx_nxt;
  logic [IDX_W-1:0]     ptr_q, ptr_nxt;
  logic [NUM_UNITS-1:0] pending_q, pending_nxt;
  logic [NUM_UNITS-1:0] act_q, act_nxt;
  logic                 done_q, done_nxt;
  logic [IDX_W-1:0]     done_id_q, done_id_nxt;
  logic                 busy_q, busy_nxt;

  logic [NUM_UNITS-1:0] pend_clr, act_set, act_clr;
  logic                 arb_vld_c;
  logic [NUM_UNITS-1:0] arb_grant_c;
  logic [IDX_W-1:0]     arb_idx_c;
  logic [HOLD_W-1:0]    grant_hold_c;
  logic [IDX_W-1:0]     gidx_inc_c;

  crcu_rr_arbiter #(
    .NUM_UNITS (NUM_UNITS)
  ) u_arb (
    .pending     (pending_q),
    .ptr         (ptr_q),
    .grant_vld_c (arb_vld_c),
    .grant_c     (arb_grant_c),
    .grant_idx_c (arb_idx_c)
  );

  assign grant_hold_c = hold[arb_idx_c];
  assign gidx_inc_c   = (gidx_q == IDX_W'(NUM_UNITS - 1)) ? '0 : gidx_q + IDX_W'(1);

  // Next-state, counter and per-unit bookkeeping.
  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    gidx_nxt    = gidx_q;
    ptr_nxt     = ptr_q;
    pend_clr    = '0;
    act_clr     = '0;
    act_set     = rst_req & async_t;
    done_nxt    = 1'b0;
    done_id_nxt = done_id_q;
    pending_nxt = pending_q;
    act_nxt     = act_q;
    busy_nxt    = busy_q;

    // Losing the enable mid-sequence abandons it without a done, but still moves the pointer on.
    if (state_q != IDLE && state_q != DONE && !en[gidx_q]) begin
      state_nxt = IDLE;
      ptr_nxt   = gidx_inc_c;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_vld_c) begin
            state_nxt = ASSERT;
            gidx_nxt  = arb_idx_c;
            pend_clr  = arb_grant_c;
            act_set   = act_set | arb_grant_c;
            cnt_nxt   = (grant_hold_c == '0) ? HOLD_W'(1) : grant_hold_c;
          end
        end
        ASSERT: state_nxt = HOLD;
        HOLD: begin
          if (cnt_q == HOLD_W'(1)) begin
            state_nxt       = RELEASE;
            act_clr[gidx_q] = 1'b1;
          end else begin
            cnt_nxt = cnt_q - HOLD_W'(1);
          end
        end
        RELEASE: begin
          state_nxt = SETTLE;
          cnt_nxt   = HOLD_W'(SETTLE_CYC);
        end
        SETTLE: begin
          if (cnt_q == HOLD_W'(1)) begin
            state_nxt   = DONE;
            done_nxt    = 1'b1;
            done_id_nxt = gidx_q;
          end else begin
            cnt_nxt = cnt_q - HOLD_W'(1);
          end
        end
        DONE: begin
          state_nxt = IDLE;
          ptr_nxt   = gidx_inc_c;
        end
        default: state_nxt = IDLE;
      endcase
    end

    // New requests win over the grant-side clear so a re-request is served later.
    pending_nxt = (pending_q & ~pend_clr) | (rst_req & en);
    act_nxt     = ((act_q & ~act_clr) | act_set) & en;
    busy_nxt    = (state_nxt != IDLE);
  end

  always_ff @(posedge CRCU_CLK or negedge CRCU_RST) begin
    if (!CRCU_RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      pending_q <= '0;
      act_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      gidx_q    <= gidx_nxt;
      ptr_q     <= ptr_nxt;
      pending_q <= pending_nxt;
      act_q     <= act_nxt;
      done_q    <= done_nxt;
      done_id_q <= done_id_nxt;
      busy_q    <= busy_nxt;
    end
  end

  // Polarity mux: active-low enabled units idle high.
  assign unit_rst = en & ~(pol ^ act_q);
  assign busy     = busy_q;
  assign done     = done_q;
  assign done_id  = done_id_q;

endmodule

// File: tb/tb_crcu_unit_rst_sequencer.sv
// Bench for crcu_unit_rst_sequencer: vector table, directed corner sequences and a random run
// checked every cycle against a timeline-based reference model.
module tb_crcu_unit_rst_sequencer;

  localparam int unsigned N = 4;
  localparam int unsigned S = 2;

  logic            CRCU_CLK = 1'b0;
  logic            CRCU_RST;
  logic [N*32-1:0] ctl;
  logic [N-1:0]    req;
  logic [N-1:0]    unit_rst;
  logic            busy;
  logic            done;
  logic [1:0]      done_id;

  int total = 0;
  int bad   = 0;
  int seen[$];

  crcu_unit_rst_sequencer #(.NUM_UNITS(N), .HOLD_W(8), .SETTLE_CYC(S)) dut (
    .CRCU_CLK    (CRCU_CLK),
    .CRCU_RST    (CRCU_RST),
    .rst_ctl_reg (ctl),
    .rst_req     (req),
    .unit_rst    (unit_rst),
    .busy        (busy),
    .done        (done),
    .done_id     (done_id)
  );

  always #5 CRCU_CLK = ~CRCU_CLK;

  // Reference model: a granted sequence is a fixed timeline measured from its grant edge m_tg.
  logic [N-1:0] m_pend, m_act;
  int m_ptr, m_g, m_h, m_tg, m_done_id, cyc;
  bit m_active, m_done;

  function automatic bit en_of(int u);    return ctl[u*32];     endfunction
  function automatic bit async_of(int u); return ctl[u*32+1];   endfunction
  function automatic bit pol_of(int u);   return ctl[u*32+2];   endfunction
  function automatic int hold_of(int u);  return int'(ctl[u*32+8 +: 8]); endfunction

  function automatic logic [N-1:0] exp_rst();
    logic [N-1:0] e;
    for (int u = 0; u < N; u++) e[u] = en_of(u) & (pol_of(u) ? m_act[u] : ~m_act[u]);
    return e;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_act = '0; m_ptr = 0; m_g = 0; m_h = 1; m_tg = 0;
    m_done_id = 0; cyc = 0; m_active = 0; m_done = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    bit found;
    cyc++;
    m_done = 0;
    if (m_active) begin
      if (cyc <= m_tg + m_h + 2 + S && !en_of(m_g)) begin
        m_active = 0;
        m_ptr = (m_g + 1) % N;
      end else begin
        if (cyc == m_tg + m_h + 1) m_act[m_g] = 0;
        if (cyc == m_tg + m_h + 2 + S) begin m_done = 1; m_done_id = m_g; end
        if (cyc == m_tg + m_h + 3 + S) begin m_active = 0; m_ptr = (m_g + 1) % N; end
      end
    end else if (m_pend != '0) begin
      found = 0;
      for (int i = 0; i < N; i++)
        if (!found && m_pend[(m_ptr + i) % N]) begin found = 1; m_g = (m_ptr + i) % N; end
      m_pend[m_g] = 0;
      m_active = 1;
      m_tg = cyc;
      m_h = (hold_of(m_g) == 0) ? 1 : hold_of(m_g);
      m_act[m_g] = 1;
    end
    for (int u = 0; u < N; u++) begin
      if (r[u] && en_of(u)) begin
        m_pend[u] = 1;
        if (async_of(u)) m_act[u] = 1;
      end
      if (!en_of(u)) m_act[u] = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, got, want);
    end
  endtask

  task automatic step(input logic [N-1:0] r);
    req = r;
    @(posedge CRCU_CLK);
    #1;
    req = '0;
    model_edge(r);
    check("cycle", {unit_rst, busy, done, done_id},
          {exp_rst(), m_active, m_done, 2'(m_done_id)});
  endtask

  task automatic do_reset();
    CRCU_RST = 1'b0;
    #1;
    model_reset();
    check("reset_out", {unit_rst, busy, done, done_id}, {exp_rst(), 4'b0});
    @(posedge CRCU_CLK);
    #1;
    CRCU_RST = 1'b1;
    #1;
    check("reset_release", {unit_rst, busy, done, done_id}, {exp_rst(), 4'b0});
  endtask

  task automatic set_unit(input int u, input bit e, input bit a, input bit p, input int h);
    ctl[u*32 +: 32] = {16'b0, 8'(h), 5'b0, p, a, e};
  endtask

  task automatic collect(input int n, input int lim);
    seen.delete();
    for (int k = 0; k < lim && seen.size() < n; k++) begin
      step('0);
      check("no_overlap", 32'($countones(unit_rst) > 1), 0);
      if (done) seen.push_back(int'(done_id));
    end
  endtask

  typedef struct {
    logic [3:0] en, asy, pol, idle;
    int unit, hold, pulse, done_k;
  } vec_t;

  vec_t vt[7];
  int exp3[3];
  int exp2[2];

  initial begin
    vt[0] = '{4'b1111, 4'b0000, 4'b1111, 4'b0000, 0, 3, 4, 9};
    vt[1] = '{4'b0011, 4'b0000, 4'b0001, 4'b0010, 1, 0, 2, 7};
    vt[2] = '{4'b1111, 4'b0100, 4'b0101, 4'b1010, 2, 1, 3, 7};
    vt[3] = '{4'b1111, 4'b0000, 4'b1010, 4'b0101, 3, 255, 256, 261};
    vt[4] = '{4'b1011, 4'b0000, 4'b1111, 4'b0000, 2, 5, 0, 0};
    vt[5] = '{4'b1111, 4'b1111, 4'b0000, 4'b1111, 0, 2, 4, 8};
    vt[6] = '{4'b1101, 4'b0000, 4'b1111, 4'b0000, 1, 3, 0, 0};
    exp3 = '{1, 2, 3};
    exp2 = '{0, 3};
    req = '0;
    CRCU_RST = 1'b0;
    ctl = '0;

    // Reset values with mixed polarities.
    set_unit(0, 1, 0, 1, 1);
    set_unit(1, 1, 0, 0, 1);
    do_reset();
    check("reset_rst_const", {unit_rst, busy, done}, {4'b0010, 2'b00});

    // Single-unit sequences from the vector table.
    foreach (vt[i]) begin
      int pulse, done_k, did, lim;
      logic idle_v;
      logic [N-1:0] r;
      for (int u = 0; u < N; u++)
        set_unit(u, vt[i].en[u], vt[i].asy[u], vt[i].pol[u], (u == vt[i].unit) ? vt[i].hold : 1);
      #1;
      check("vec_idle", unit_rst, vt[i].idle);
      idle_v = unit_rst[vt[i].unit];
      pulse = 0; done_k = 0; did = -1;
      lim = (vt[i].done_k == 0) ? 20 : vt[i].done_k + 10;
      for (int k = 1; k <= lim && done_k == 0; k++) begin
        r = (k == 1) ? (N'(1) << vt[i].unit) : '0;
        step(r);
        if (unit_rst[vt[i].unit] != idle_v) pulse++;
        if (done) begin done_k = k; did = int'(done_id); end
      end
      check("vec_pulse", pulse, vt[i].pulse);
      check("vec_done_k", done_k, vt[i].done_k);
      check("vec_done_id", did, (vt[i].done_k == 0) ? -1 : vt[i].unit);
      step('0);
    end

    // Round-robin order: 1,2,3 then 0,3.
    for (int u = 0; u < N; u++) set_unit(u, 1, 0, 1, 1);
    do_reset();
    step(4'b1110);
    collect(3, 100);
    check("rr_count_a", seen.size(), 3);
    for (int i = 0; i < 3; i++) check("rr_order_a", (i < seen.size()) ? seen[i] : -1, exp3[i]);
    step(4'b1001);
    collect(2, 100);
    check("rr_count_b", seen.size(), 2);
    for (int i = 0; i < 2; i++) check("rr_order_b", (i < seen.size()) ? seen[i] : -1, exp2[i]);

    // Async unit requested while another unit holds.
    begin
      int done1, fall2, pulse2;
      bit fin;
      for (int u = 0; u < N; u++) set_unit(u, 1, 0, 1, 1);
      set_unit(1, 1, 0, 1, 4);
      set_unit(2, 1, 1, 1, 2);
      do_reset();
      step(4'b0010);
      step('0);
      step('0);
      step(4'b0100);
      check("async_early", unit_rst[2], 1);
      done1 = -1; fall2 = -1; pulse2 = 1; fin = 0;
      for (int k = 0; k < 100 && !fin; k++) begin
        step('0);
        if (unit_rst[2]) pulse2++;
        else if (fall2 < 0) fall2 = cyc;
        if (done && done_id == 2'd1) done1 = cyc;
        if (done && done_id == 2'd2) fin = 1;
      end
      check("async_done", fin, 1);
      check("async_release_after", (fall2 > done1) && (done1 > 0), 1);
      check("async_pulse_len", pulse2 >= 3, 1);
    end

    // Enable dropped mid-HOLD: no done for unit0, unit1 served next.
    for (int u = 0; u < N; u++) set_unit(u, 1, 0, 1, 1);
    set_unit(0, 1, 0, 1, 5);
    do_reset();
    step(4'b0011);
    step('0);
    step('0);
    step('0);
    set_unit(0, 0, 0, 1, 5);
    step('0);
    check("abort_rst", {unit_rst[0], busy}, 2'b00);
    step('0);
    check("abort_next_busy", busy, 1);
    collect(1, 50);
    check("abort_next_id", (seen.size() > 0) ? seen[0] : -1, 1);

    // Reset asserted mid-HOLD.
    set_unit(0, 1, 0, 1, 5);
    step(4'b0001);
    step('0);
    step('0);
    step('0);
    #2;
    CRCU_RST = 1'b0;
    #1;
    check("rst_mid_hold", {unit_rst, busy, done}, 6'b0);
    do_reset();

    // Random traffic against the model.
    for (int seg = 0; seg < 6; seg++) begin
      for (int u = 0; u < N; u++)
        set_unit(u, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 6));
      for (int k = 0; k < 80; k++) begin
        logic [N-1:0] r;
        for (int u = 0; u < N; u++) r[u] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 19) == 0) ctl[$urandom_range(0, N-1)*32 + 2] ^= 1'b1;
        if ($urandom_range(0, 29) == 0) ctl[$urandom_range(0, N-1)*32] ^= 1'b1;
        step(r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
